// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: one request in flight, RV32I width
// rules over a little-endian word RAM, configurable wait states before commit.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int ADDR_W = IDX_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [3:0]         count;
    logic               write_q;
    logic [2:0]         funct3_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        ram [DEPTH_WORDS];

    function automatic logic is_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (wr) bad = (f3 == 3'b011) || f3[2];
        else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if ((f3[1:0] == 2'b01) && a[0])           bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) bad = 1'b1;
        if ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS)) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    logic               accept;
    logic               req_bad;
    logic               commit;
    logic               c_write;
    logic [2:0]         c_funct3;
    logic [ADDR_W-1:0]  c_addr;
    logic [31:0]        c_wdata;
    logic [IDX_W-1:0]   c_idx;
    logic [3:0]         c_be;
    logic [31:0]        rd_word;
    logic [31:0]        wr_word;
    logic [31:0]        load_val;

    assign accept  = (state == S_IDLE) && req_valid;
    assign req_bad = is_bad(req_write, req_funct3, req_addr);

    // With zero wait states the commit happens on the accept edge, straight from the inputs
    assign c_write  = (state == S_IDLE) ? req_write                : write_q;
    assign c_funct3 = (state == S_IDLE) ? req_funct3               : funct3_q;
    assign c_addr   = (state == S_IDLE) ? req_addr[ADDR_W-1:0]     : addr_q;
    assign c_wdata  = (state == S_IDLE) ? req_wdata                : wdata_q;

    assign commit   = reset && ((accept && !req_bad && (WAIT_CYCLES == 0)) ||
                                ((state == S_WAIT) && (count == 4'd0)));
    assign c_idx    = c_addr[ADDR_W-1:2];
    assign rd_word  = ram[c_idx];
    assign c_be     = lane_enable(c_funct3[1:0], c_addr[1:0]);
    assign wr_word  = lane_data(c_funct3[1:0], c_wdata);
    assign load_val = c_write ? 32'd0 : load_extend(c_funct3, c_addr[1:0], rd_word);

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W-1:0];
            wdata_q  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_write) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) ram[c_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (WAIT_CYCLES == 0) begin
                            rsp_error <= 1'b0;
                            rsp_rdata <= load_val;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            count <= 4'(WAIT_CYCLES - 1);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == 4'd0) begin
                        rsp_error <= 1'b0;
                        rsp_rdata <= load_val;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
